display_scheduler: RTL

Sequences the four-digit seven-segment display between the hardwired password message and the ciphertext message produced by the encryption core. It owns digit scanning (anode strobe plus symbol selection), the PASS/ENCR dwell alternation, and a valid/ready load port that buffers new ciphertext without tearing the message currently on screen. It emits 5-bit symbol codes; the downstream cathode decoders convert them to segment patterns.

---
 rtl/display_pkg.sv | 19 +
 rtl/digit_scanner.sv | 33 +++
 rtl/display_scheduler.sv | 111 +++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared widths, phase encoding and digit field helper for the display scheduler
package display_pkg;

    localparam int DIGITS = 4;
    localparam int CODE_W = 5;
    localparam int MSG_W  = 20;

    typedef enum logic {
        SHOW_PASS = 1'b0,
        SHOW_ENCR = 1'b1
    } phase_t;

    // Digit 0 is the rightmost digit and lives in the low bits of the message.
    function automatic logic [CODE_W-1:0] digit_field(input logic [MSG_W-1:0] msg,
                                                      input logic [1:0]       idx);
        return msg[idx*CODE_W +: CODE_W];
    endfunction

endpackage

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - refresh divider, digit index and active-low anode strobe
module digit_scanner #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] d,
    output logic       digit_adv,
    output logic [3:0] anode
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       d_next;

    assign digit_adv = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    assign d_next    = digit_adv ? d + 2'd1 : d;

    // anode is decoded from d_next so it changes on the same edge as d.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            d           <= 2'd0;
            anode       <= 4'b1110;
        end else begin
            refresh_cnt <= digit_adv ? '0 : refresh_cnt + 1'b1;
            d           <= d_next;
            anode       <= ~(4'b0001 << d_next);
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - PASS/ENCR dwell alternation, tear-free ciphertext load and digit symbol mux
module display_scheduler
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int DWELL_CYCLES = 200_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MSG_W-1:0]  pass_code,
    input  logic [MSG_W-1:0]  enc_code,
    input  logic              enc_valid,
    output logic              enc_ready,
    input  logic              hold,
    output logic [3:0]        anode,
    output logic [CODE_W-1:0] sym_code,
    output logic              showing_encr
);

    localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    phase_t             state, state_next;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               dwell_wrap;
    logic               commit;
    logic               accept;

    logic [MSG_W-1:0]   shadow;
    logic               shadow_full;
    logic [MSG_W-1:0]   active_enc;
    logic               enc_loaded;

    logic [1:0]         d;
    logic               digit_adv;
    logic [1:0]         d_next;
    logic [MSG_W-1:0]   msg_next;
    logic [CODE_W-1:0]  sym_next;

    digit_scanner #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .digit_adv (digit_adv),
        .anode     (anode)
    );

    assign enc_ready  = ~shadow_full;
    assign accept     = enc_valid & ~shadow_full;
    assign dwell_wrap = ~hold & (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));

    // Commits are only taken on the PASS->ENCR transition so a message is never swapped mid-phase.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        if (dwell_wrap) begin
            if (state == SHOW_PASS) begin
                if (shadow_full) begin
                    commit     = 1'b1;
                    state_next = SHOW_ENCR;
                end else if (enc_loaded) begin
                    state_next = SHOW_ENCR;
                end
            end else begin
                state_next = SHOW_PASS;
            end
        end
    end

    // Symbol is computed from next-cycle digit and phase so it lands with the anode.
    always_comb begin
        d_next   = digit_adv ? d + 2'd1 : d;
        msg_next = pass_code;
        if (state_next == SHOW_ENCR) begin
            msg_next = commit ? shadow : active_enc;
        end
        sym_next = digit_field(msg_next, d_next);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SHOW_PASS;
            dwell_cnt    <= '0;
            shadow       <= '0;
            shadow_full  <= 1'b0;
            active_enc   <= '0;
            enc_loaded   <= 1'b0;
            sym_code     <= pass_code[CODE_W-1:0];
            showing_encr <= 1'b0;
        end else begin
            state <= state_next;
            if (!hold) begin
                dwell_cnt <= dwell_wrap ? '0 : dwell_cnt + 1'b1;
            end
            if (accept) begin
                shadow      <= enc_code;
                shadow_full <= 1'b1;
            end else if (commit) begin
                shadow_full <= 1'b0;
            end
            if (commit) begin
                active_enc <= shadow;
                enc_loaded <= 1'b1;
            end
            sym_code     <= sym_next;
            showing_encr <= (state_next == SHOW_ENCR);
        end
    end

endmodule
